// File: rtl/memory_unit_v2.sv
// Memory/fetch block: PC, stack pointer, instruction register, multi-cycle ROM fetch,
// RAM address generation and a muxed data-bus driver with conflict detection.
module memory_unit_v2 #(
    parameter int unsigned     DATA_W      = 8,
    parameter int unsigned     PC_W        = 16,
    parameter int unsigned     ROM_AW      = 15,
    parameter int unsigned     OPC_W       = 8,
    parameter int unsigned     IMM_W       = 16,
    parameter int unsigned     SP_W        = 8,
    parameter int unsigned     ROM_LAT     = 1,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter bit              SP_SATURATE = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [DATA_W-1:0]      i_bus,
    output logic [DATA_W-1:0]      o_bus,
    output logic                   o_busDrive,
    output logic                   o_busConflict,
    output logic [OPC_W-1:0]       o_instrCode,
    output logic                   o_instrValid,
    input  logic                   i_ctrlNotPCIncr,
    input  logic                   i_ctrlNotPCLoad,
    input  logic                   i_ctrlPCRel,
    input  logic                   i_ctrlSpDirection,
    input  logic                   i_ctrlNotSpEn,
    input  logic                   i_ctrlFlagClr,
    input  logic                   i_ctrlInstrNWE,
    input  logic                   i_ctrlInstrImmNOE,
    input  logic                   i_ctrlInstrImmHi,
    input  logic                   i_ctrlRamNOE,
    input  logic                   i_ctrlRamNWE,
    output logic [ROM_AW-1:0]      o_romAddress,
    output logic                   o_romRead,
    input  logic [OPC_W+IMM_W-1:0] i_romData,
    output logic [IMM_W:0]         o_ramAddress,
    input  logic [DATA_W-1:0]      i_ramData,
    output logic [DATA_W-1:0]      o_ramData,
    output logic                   o_ramWE,
    output logic                   o_spOverflow,
    output logic                   o_spUnderflow
);

    localparam int unsigned INSTR_W = OPC_W + IMM_W;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROM_AW-1:0]    fetch_addr_q, fetch_addr_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 valid_q, valid_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [SP_W-1:0]      sp_q, sp_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic [IMM_W-1:0]     imm;
    logic [PC_W-1:0]      imm_abs;
    logic [PC_W-1:0]      imm_rel;
    logic [DATA_W-1:0]    imm_byte;
    logic                 stack_sel;
    logic                 ram_oe;
    logic                 imm_oe;

    assign imm         = instr_q[IMM_W-1:0];
    assign o_instrCode = instr_q[INSTR_W-1:IMM_W];

    // Truncation is already correct modulo 2^PC_W, so only narrower immediates need extending.
    if (IMM_W >= PC_W) begin : g_imm_trunc
        assign imm_abs = imm[PC_W-1:0];
        assign imm_rel = imm[PC_W-1:0];
    end else begin : g_imm_ext
        assign imm_abs = {{(PC_W-IMM_W){1'b0}}, imm};
        assign imm_rel = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    end

    always_comb begin
        pc_d = pc_q;
        if (!i_ctrlNotPCLoad) begin
            pc_d = i_ctrlPCRel ? pc_q + imm_rel : imm_abs;
        end else if (!i_ctrlNotPCIncr) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_comb begin
        sp_d  = sp_q;
        ovf_d = i_ctrlFlagClr ? 1'b0 : ovf_q;
        unf_d = i_ctrlFlagClr ? 1'b0 : unf_q;
        if (!i_ctrlNotSpEn) begin
            if (i_ctrlSpDirection) begin
                if (&sp_q) begin
                    ovf_d = 1'b1;
                    if (!SP_SATURATE) sp_d = '0;
                end else begin
                    sp_d = sp_q + SP_W'(1);
                end
            end else begin
                if (sp_q == '0) begin
                    unf_d = 1'b1;
                    if (!SP_SATURATE) sp_d = '1;
                end else begin
                    sp_d = sp_q - SP_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fetch_addr_d = fetch_addr_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        o_romRead    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!i_ctrlInstrNWE) begin
                    fetch_addr_d = pc_q[ROM_AW-1:0];
                    if (ROM_LAT == 0) begin
                        instr_d = i_romData;
                        valid_d = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_W'(ROM_LAT);
                        valid_d = 1'b0;
                    end
                end
            end
            StWait: begin
                o_romRead = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    instr_d = i_romData;
                    valid_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Address is frozen while waiting so PC updates cannot disturb an in-flight read.
    assign o_romAddress = (state_q == StWait) ? fetch_addr_q : pc_q[ROM_AW-1:0];
    assign o_instrValid = valid_q;

    assign stack_sel    = &imm[IMM_W-1:IMM_W-SP_W];
    assign o_ramAddress = stack_sel ? {1'b1, sp_q, imm[IMM_W-SP_W-1:0]} : {1'b0, imm};
    assign o_ramData    = i_bus;
    assign o_ramWE      = ~i_ctrlRamNWE;

    assign ram_oe        = ~i_ctrlRamNOE;
    assign imm_oe        = ~i_ctrlInstrImmNOE;
    assign imm_byte      = i_ctrlInstrImmHi ? imm[2*DATA_W-1:DATA_W] : imm[DATA_W-1:0];
    assign o_busDrive    = ram_oe | imm_oe;
    assign o_busConflict = ram_oe & imm_oe;
    assign o_bus         = ram_oe ? i_ramData : (imm_oe ? imm_byte : '0);

    assign o_spOverflow  = ovf_q;
    assign o_spUnderflow = unf_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            fetch_addr_q <= RESET_PC[ROM_AW-1:0];
            instr_q      <= '0;
            valid_q      <= 1'b0;
            pc_q         <= RESET_PC;
            sp_q         <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fetch_addr_q <= fetch_addr_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

endmodule
